// File: rtl/dout_rr_arbiter.sv
// rtl/dout_rr_arbiter.sv - round-robin burst arbiter sharing one registered dout stream among REQ_NUM requesters
// Optional forced release of a stalled owner: define DOUT_ARB_TIMEOUT_EN.
module dout_rr_arbiter #(
    parameter int DWIDTH    = 16,
    parameter int REQ_NUM   = 4,
    parameter int BURST_MAX = 8,
    parameter int TIMEOUT   = 16,
    localparam int IW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
    localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REQ_NUM-1:0]        req_valid,
    input  logic [REQ_NUM*DWIDTH-1:0] req_data,
    input  logic [REQ_NUM-1:0]        req_last,
    output logic [REQ_NUM-1:0]        req_ready,
    output logic                      dout_valid,
    output logic [DWIDTH-1:0]         dout_data,
    input  logic                      dout_ready,
    output logic [IW-1:0]             grant_id,
    output logic                      busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       pick;
    logic [IW-1:0]       next_ptr;
    logic [CW-1:0]       beat_cnt;
    logic [DWIDTH-1:0]   owner_data;
    logic                found;
    logic                owner_valid;
    logic                out_free;
    logic                accept;
    logic                burst_end;
    logic                stall_end;

    assign owner_valid = req_valid[grant_id];
    assign owner_data  = req_data[grant_id*DWIDTH +: DWIDTH];
    assign out_free    = !dout_valid || dout_ready;
    assign next_ptr    = (grant_id == IW'(REQ_NUM-1)) ? '0 : grant_id + 1'b1;
    assign busy        = (state_q == GRANT);

    // Circular search starting at rr_ptr; the first hit wins.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= REQ_NUM) idx = idx - REQ_NUM;
            cand = IW'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

`ifdef DOUT_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] idle_cnt;

    // Release fires on the TIMEOUT-th consecutive cycle the owner has nothing to send.
    assign stall_end = busy && !owner_valid && (idle_cnt == TW'(TIMEOUT-1));

    always_ff @(posedge clk) begin
        if (rst || !busy || accept || stall_end) begin
            idle_cnt <= '0;
        end else if (!owner_valid) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign stall_end = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        burst_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) state_d = GRANT;
            end
            GRANT: begin
                req_ready[grant_id] = out_free;
                accept    = owner_valid && out_free;
                burst_end = accept && (req_last[grant_id] || beat_cnt == CW'(BURST_MAX-1));
                if (burst_end || stall_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            beat_cnt   <= '0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && found) begin
                grant_id <= pick;
                beat_cnt <= '0;
            end
            // A draining beat in IDLE still clears on dout_ready.
            if (accept) begin
                dout_valid <= 1'b1;
                dout_data  <= owner_data;
                beat_cnt   <= beat_cnt + 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (burst_end || stall_end) rr_ptr <= next_ptr;
        end
    end

endmodule

// File: tb/tb_dout_rr_arbiter.sv
// tb/tb_dout_rr_arbiter.sv - scoreboard bench for dout_rr_arbiter with directed per-requester packet queues
module tb_dout_rr_arbiter;

    localparam int DW = 16;
    localparam int RN = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [RN-1:0]   req_valid = '0;
    logic [RN*DW-1:0] req_data = '0;
    logic [RN-1:0]   req_last = '0;
    logic [RN-1:0]   req_ready;
    logic            dout_valid;
    logic [DW-1:0]   dout_data;
    logic            dout_ready = 1'b1;
    logic [1:0]      grant_id;
    logic            busy;

    logic [16:0]     rq [RN][$];
    logic [15:0]     exp_q [$];
    int              xfer_cyc [$];
    int              cyc = 0;
    int              checks = 0;
    int              failures = 0;
    int              t0;
    logic [RN-1:0]   fire;

    dout_rr_arbiter #(.DWIDTH(DW), .REQ_NUM(RN), .BURST_MAX(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .dout_valid(dout_valid), .dout_data(dout_data), .dout_ready(dout_ready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int r, input logic [15:0] base, input int n, input bit with_last, input bit expect_it);
        for (int k = 0; k < n; k++) begin
            rq[r].push_back({(with_last && k == n-1), base + 16'(k)});
            if (expect_it) exp_q.push_back(base + 16'(k));
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || dout_valid) && n < budget) begin
            tick();
            n++;
        end
        check(name, (n >= budget), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Requester models: present queue heads at negedge, retire the head on a handshake.
    initial begin : driver
        forever begin
            @(negedge clk);
            for (int i = 0; i < RN; i++) begin
                if (rq[i].size() > 0) begin
                    req_valid[i]          = 1'b1;
                    req_data[i*DW +: DW]  = rq[i][0][15:0];
                    req_last[i]           = rq[i][0][16];
                end else begin
                    req_valid[i]          = 1'b0;
                    req_data[i*DW +: DW]  = '0;
                    req_last[i]           = 1'b0;
                end
            end
            #4;
            fire = req_valid & req_ready;
            @(posedge clk);
            for (int i = 0; i < RN; i++)
                if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
    end

    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (dout_valid && dout_ready) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {16'h0, dout_data}, 32'hdead_beef);
                end else begin
                    e = exp_q.pop_front();
                    check("dout_data", {16'h0, dout_data}, {16'h0, e});
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        do_reset();
        check("rst_dout_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_dout_data", dout_data, 0);

        // Single requester 2, three beats; first beat two cycles after valid rises.
        tick();
        xfer_cyc.delete();
        rq[2].push_back({1'b0, 16'h0011}); exp_q.push_back(16'h0011);
        rq[2].push_back({1'b0, 16'h0022}); exp_q.push_back(16'h0022);
        rq[2].push_back({1'b1, 16'h0033}); exp_q.push_back(16'h0033);
        t0 = cyc;
        wait_drain("t1_drain", 40);
        check("t1_xfers", xfer_cyc.size(), 3);
        for (int k = 0; k < 3; k++)
            check("t1_latency", (k < xfer_cyc.size()) ? xfer_cyc[k] - t0 : -1, 2 + k);
        check("t1_grant_id", grant_id, 2);
        check("t1_busy", busy, 0);
        // rr_ptr is now 3: requester 3 beats requester 0.
        send(0, 16'h0100, 1, 1, 0);
        send(3, 16'h0300, 1, 1, 1);
        exp_q.push_back(16'h0100);
        wait_drain("t1_rr_drain", 40);

        // All four valid with single-beat packets: order 0,1,2,3,0 every 2 cycles.
        do_reset();
        tick();
        xfer_cyc.delete();
        send(0, 16'h0001, 1, 1, 1);
        send(1, 16'h1001, 1, 1, 1);
        send(2, 16'h2001, 1, 1, 1);
        send(3, 16'h3001, 1, 1, 1);
        send(0, 16'h0002, 1, 1, 1);
        wait_drain("t2_drain", 60);
        check("t2_xfers", xfer_cyc.size(), 5);
        for (int k = 0; k < 4; k++)
            check("t2_gap", (k + 1 < xfer_cyc.size()) ? xfer_cyc[k+1] - xfer_cyc[k] : -1, 2);

        // Requester 1 streams 20 unterminated beats, others interleaved (rr_ptr=1).
        tick();
        send(1, 16'h1100, 20, 0, 0);
        send(2, 16'h2100, 1, 1, 0); send(2, 16'h2101, 1, 1, 0);
        send(3, 16'h3100, 1, 1, 0); send(3, 16'h3101, 1, 1, 0);
        send(0, 16'h0100, 1, 1, 0); send(0, 16'h0101, 1, 1, 0);
        for (int k = 0; k < 8; k++) exp_q.push_back(16'h1100 + 16'(k));
        exp_q.push_back(16'h2100); exp_q.push_back(16'h3100); exp_q.push_back(16'h0100);
        for (int k = 8; k < 16; k++) exp_q.push_back(16'h1100 + 16'(k));
        exp_q.push_back(16'h2101); exp_q.push_back(16'h3101); exp_q.push_back(16'h0101);
        for (int k = 16; k < 20; k++) exp_q.push_back(16'h1100 + 16'(k));
        wait_drain("t3_drain", 150);
        check("t3_hold_busy", busy, 1);
        check("t3_hold_grant", grant_id, 1);

        // Backpressure for 5 cycles once the first beat is captured.
        do_reset();
        tick();
        xfer_cyc.delete();
        send(0, 16'h0A00, 6, 1, 1);
        n = 0;
        while (!dout_valid && n < 10) begin tick(); n++; end
        check("t4_first_beat_timeout", (n >= 10), 0);
        dout_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_hold_valid", dout_valid, 1);
            check("t4_hold_data", dout_data, 16'h0A00);
            check("t4_req_ready", req_ready, 0);
        end
        dout_ready = 1'b1;
        wait_drain("t4_drain", 40);
        check("t4_xfers", xfer_cyc.size(), 6);

        // Reset during beat 3 of a burst from requester 2 while rr_ptr=3.
        do_reset();
        tick();
        send(2, 16'h2200, 1, 1, 1);
        wait_drain("t5_pre_drain", 40);
        tick();
        send(2, 16'h2300, 6, 1, 1);
        n = 0;
        while (!(dout_valid && dout_data == 16'h2302) && n < 20) begin tick(); n++; end
        check("t5_beat3_timeout", (n >= 20), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_dout_valid", dout_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_grant_id", grant_id, 0);
        check("t5_req_ready", req_ready, 0);
        exp_q.delete();
        rq[2].delete();
        send(3, 16'h3300, 1, 1, 0);
        send(1, 16'h1300, 1, 1, 1);
        exp_q.push_back(16'h3300);
        wait_drain("t5_post_drain", 40);

        // Owner 0 stalls after two beats while requester 3 waits.
        do_reset();
        tick();
        send(0, 16'h0600, 2, 0, 1);
        wait_drain("t6_drain", 40);
        send(3, 16'h3600, 1, 1, 0);
`ifdef DOUT_ARB_TIMEOUT_EN
        exp_q.push_back(16'h3600);
        for (int k = 0; k < 100; k++) tick();
        check("t6_busy", busy, 0);
        check("t6_grant_id", grant_id, 3);
        check("t6_req3_pending", rq[3].size(), 0);
`else
        for (int k = 0; k < 100; k++) tick();
        check("t6_busy", busy, 1);
        check("t6_grant_id", grant_id, 0);
        check("t6_req3_pending", rq[3].size(), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dout_rr_arbiter.md
Name: dout_rr_arbiter

Overview:
- Round-robin arbiter and burst scheduler that shares one dout stream (dout_valid/dout_data, DWIDTH wide) between REQ_NUM requesters.
- Grants one requester at a time for a burst, terminated by req_last or by the BURST_MAX beat limit.
- Registers the selected beat onto the shared output with valid/ready flow control.
- Sits between multiple data producers and the single dout consumer.

Parameters:
- DWIDTH, 16, data width of every requester and of dout_data.
- REQ_NUM, 4, number of requesters; legal range 2..16.
- BURST_MAX, 8, maximum beats per grant; legal range 1..256.
- TIMEOUT, 16, idle cycles before forced release; used only with DOUT_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  REQ_NUM  per-requester beat valid.
- req_data  input  REQ_NUM*DWIDTH  per-requester data; requester i occupies bits [i*DWIDTH +: DWIDTH].
- req_last  input  REQ_NUM  per-requester last beat of packet, qualified by req_valid.
- req_ready  output  REQ_NUM  per-requester beat accepted this cycle.
- dout_valid  output  1  shared output beat valid.
- dout_data  output  DWIDTH  shared output data.
- dout_ready  input  1  downstream accepts the dout beat.
- grant_id  output  max(1,$clog2(REQ_NUM))  index of the current or last owner.
- busy  output  1  high while in GRANT state.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, dout_valid=0, dout_data=0, busy=0, req_ready=0. Any beat held in the output register is discarded.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req_valid is high, select the first i with req_valid[i]=1, searching circularly from rr_ptr.
  - Load grant_id=i, beat_cnt=0, go to GRANT.
  - No beat is transferred in the IDLE cycle: a 1-cycle arbitration bubble per burst.
  - If no req_valid is high, stay in IDLE.
- GRANT:
  - req_ready[grant_id] = (!dout_valid || dout_ready). All other req_ready bits are 0.
  - Beat accepted when req_valid[grant_id] && req_ready[grant_id]. On accept, the output register loads req_data of grant_id, dout_valid=1, beat_cnt++.
  - dout_valid clears when dout_ready=1 and no new beat is accepted in the same cycle.
  - Latency: 1 cycle from accept to dout_valid. Full throughput of 1 beat/cycle when dout_ready is held high.
  - Burst ends on an accepted beat with req_last[grant_id]=1 or with beat_cnt==BURST_MAX-1.
  - At burst end: rr_ptr=(grant_id+1) mod REQ_NUM, go to IDLE. The final beat still drains through the output register normally.
  - Owner drops req_valid mid-burst: grant is held and the arbiter waits. Other requesters are not serviced (without the optional feature).
- dout_valid/dout_data stay stable while dout_valid=1 && dout_ready=0.
- In IDLE, dout_valid may still be high while draining; this does not block arbitration. The next burst's first accept waits for dout_ready.
- grant_id holds its value in IDLE until the next grant.
- Simultaneous requests: rr_ptr alone decides the winner, with no fixed priority. Each requester waits at most REQ_NUM-1 bursts.
- Wrap-around: with rr_ptr=REQ_NUM-1, the search continues at index 0.
- rst asserted mid-burst: immediate return to reset state on that edge. The partial burst is lost, and the requester must resend.

Optional Feature:
- Macro: DOUT_ARB_TIMEOUT_EN.
- With the macro defined:
  - An idle counter counts GRANT cycles with req_valid[grant_id]=0 and clears on any accept.
  - When the counter reaches TIMEOUT, the burst is force-ended: rr_ptr=grant_id+1, go to IDLE, counter cleared.
- Without the macro: no counter, TIMEOUT is ignored, and the grant is held indefinitely until req_last or BURST_MAX.

Test Plan:
- Reset then single requester: req 2 sends 3 beats 0x0011,0x0022,0x0033 with last on the third, dout_ready=1. Required response: grant_id=2; dout shows those values on 3 consecutive cycles starting 2 cycles after req_valid rises; then IDLE; rr_ptr=3.
- All 4 requesters valid continuously, 1-beat packets (last=1), rr_ptr=0. Required response: grant order 0,1,2,3,0; one output beat every 2 cycles.
- Requester 1 streams 20 beats with no last, BURST_MAX=8. Required response: bursts of 8,8,4 beats; the other valid requesters are interleaved between bursts.
- Backpressure: dout_ready=0 for 5 cycles mid-burst. Required response: dout_data holds; req_ready[owner]=0 after the first beat is captured; no beat lost or duplicated once dout_ready returns to 1.
- rst pulsed during beat 3 of a burst. Required response: next cycle dout_valid=0, busy=0, grant_id=0; next arbitration starts from rr_ptr=0.
- With DOUT_ARB_TIMEOUT_EN and TIMEOUT=16: owner 0 stalls after 2 beats while requester 3 is waiting. Required response: after 16 idle cycles, release to IDLE and grant requester 3. Without the macro: owner 0 is still granted at 100 cycles.
